// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the CDB lane payload carried from the FUs to the ROB/RS.
package rv32i_types;

    localparam int CDB_ROB_W = 4;

    typedef struct packed {
        logic [CDB_ROB_W-1:0] rob;
        logic [31:0]          rd_v;
        logic                 is_branch;
        logic                 branch_take;
        logic [31:0]          branch_pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_lane_picker.sv
// Combinational round-robin picker: scans FUs from rr_ptr, grants up to CDB_SIZE valid
// requesters into lanes in scan order, and lets at most one branch result through.
module rr_lane_picker #(
    parameter int NUM_FU   = 5,
    parameter int CDB_SIZE = 3,
    parameter int PTR_W    = 3
) (
    input  logic [NUM_FU-1:0]               valid,
    input  logic [NUM_FU-1:0]               is_branch,
    input  logic [PTR_W-1:0]                rr_ptr,
    output logic [NUM_FU-1:0]               grant,
    output logic [CDB_SIZE-1:0]             lane_used,
    output logic [CDB_SIZE-1:0][PTR_W-1:0]  lane_idx,
    output logic [PTR_W-1:0]                last_idx,
    output logic                            any_grant
);

    localparam int CNT_W = $clog2(CDB_SIZE + 1);

    logic [CNT_W-1:0] n;
    logic             br_taken;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        lane_used = '0;
        lane_idx  = '0;
        last_idx  = '0;
        any_grant = 1'b0;
        n         = '0;
        br_taken  = 1'b0;
        idx       = rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            // A second branch in the same scan is skipped, later non-branches still compete.
            if (valid[idx] && (n != CNT_W'(CDB_SIZE)) && !(is_branch[idx] && br_taken)) begin
                grant[idx]    = 1'b1;
                lane_used[n]  = 1'b1;
                lane_idx[n]   = idx;
                last_idx      = idx;
                any_grant     = 1'b1;
                if (is_branch[idx]) br_taken = 1'b1;
                n = n + 1'b1;
            end
            idx = (idx == PTR_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares CDB_SIZE common-data-bus lanes among NUM_FU result ports with round-robin
// priority; lanes are registered, so an accepted result shows on the CDB one cycle later.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU    = 5,
    parameter int CDB_SIZE  = 3,
    parameter int ROB_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               move_flush,
    input  logic [NUM_FU-1:0]                  fu_valid,
    output logic [NUM_FU-1:0]                  fu_ready,
    input  logic [NUM_FU-1:0][ROB_DEPTH-1:0]   fu_rob,
    input  logic [NUM_FU-1:0][31:0]            fu_rd_v,
    input  logic [NUM_FU-1:0]                  fu_is_branch,
    input  logic [NUM_FU-1:0]                  fu_branch_take,
    input  logic [NUM_FU-1:0][31:0]            fu_branch_pc,
    output logic [CDB_SIZE-1:0]                cdb_valid,
    output logic [CDB_SIZE-1:0][ROB_DEPTH-1:0] cdb_rob,
    output logic [CDB_SIZE-1:0][31:0]          cdb_rd_v,
    output logic                               cdb_branch_take,
    output logic [31:0]                        cdb_branch_pc
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]               rr_ptr;
    logic [NUM_FU-1:0]              grant;
    logic [CDB_SIZE-1:0]            lane_used;
    logic [CDB_SIZE-1:0][PTR_W-1:0] lane_idx;
    logic [PTR_W-1:0]               last_idx;
    logic                           any_grant;
    logic                           kill;
    logic [PTR_W-1:0]               rr_next;

    cdb_entry_t [CDB_SIZE-1:0] lane_d;
    cdb_entry_t [CDB_SIZE-1:0] lane_q;
    logic       [CDB_SIZE-1:0] valid_q;

    rr_lane_picker #(
        .NUM_FU   (NUM_FU),
        .CDB_SIZE (CDB_SIZE),
        .PTR_W    (PTR_W)
    ) u_picker (
        .valid     (fu_valid),
        .is_branch (fu_is_branch),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .lane_used (lane_used),
        .lane_idx  (lane_idx),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    // Reset and flush both refuse every result so nothing is lost into a dropped lane.
    assign kill     = rst | move_flush;
    assign fu_ready = kill ? '0 : grant;
    assign rr_next  = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;

    always_comb begin
        lane_d = '0;
        for (int l = 0; l < CDB_SIZE; l++) begin
            if (lane_used[l]) begin
                lane_d[l].rob         = CDB_ROB_W'(fu_rob[lane_idx[l]]);
                lane_d[l].rd_v        = fu_rd_v[lane_idx[l]];
                lane_d[l].is_branch   = fu_is_branch[lane_idx[l]];
                lane_d[l].branch_take = fu_branch_take[lane_idx[l]];
                lane_d[l].branch_pc   = fu_branch_pc[lane_idx[l]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            rr_ptr  <= '0;
            valid_q <= '0;
            lane_q  <= '0;
        end else begin
            valid_q <= lane_used;
            lane_q  <= lane_d;
            if (any_grant) rr_ptr <= rr_next;
        end
    end

    always_comb begin
        cdb_branch_take = 1'b0;
        cdb_branch_pc   = '0;
        for (int l = 0; l < CDB_SIZE; l++) begin
            cdb_valid[l] = valid_q[l];
            cdb_rob[l]   = ROB_DEPTH'(lane_q[l].rob);
            cdb_rd_v[l]  = lane_q[l].rd_v;
            // The picker admits at most one branch lane, so this never merges two.
            if (valid_q[l] && lane_q[l].is_branch) begin
                cdb_branch_take = lane_q[l].branch_take;
                cdb_branch_pc   = lane_q[l].branch_pc;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: the driver checks fu_ready in-cycle and queues the
// expected CDB bundle; a negedge monitor pops and compares it one cycle later.
module tb_cdb_arbiter;

    localparam int W = 3 + 12 + 96 + 1 + 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             move_flush = 1'b0;
    logic [4:0]       fu_valid = '0;
    logic [4:0]       fu_ready;
    logic [4:0][3:0]  fu_rob;
    logic [4:0][31:0] fu_rd_v;
    logic [4:0]       fu_is_branch = '0;
    logic [4:0]       fu_branch_take;
    logic [4:0][31:0] fu_branch_pc;
    logic [2:0]       cdb_valid;
    logic [2:0][3:0]  cdb_rob;
    logic [2:0][31:0] cdb_rd_v;
    logic             cdb_branch_take;
    logic [31:0]      cdb_branch_pc;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;

    cdb_arbiter #(.NUM_FU(5), .CDB_SIZE(3), .ROB_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .move_flush      (move_flush),
        .fu_valid        (fu_valid),
        .fu_ready        (fu_ready),
        .fu_rob          (fu_rob),
        .fu_rd_v         (fu_rd_v),
        .fu_is_branch    (fu_is_branch),
        .fu_branch_take  (fu_branch_take),
        .fu_branch_pc    (fu_branch_pc),
        .cdb_valid       (cdb_valid),
        .cdb_rob         (cdb_rob),
        .cdb_rd_v        (cdb_rd_v),
        .cdb_branch_take (cdb_branch_take),
        .cdb_branch_pc   (cdb_branch_pc)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack_bundle(input logic [2:0] v, input logic [11:0] tags,
                                                 input logic [95:0] vals, input logic take,
                                                 input logic [31:0] pc);
        logic [11:0] t;
        logic [95:0] d;
        t = '0;
        d = '0;
        for (int l = 0; l < 3; l++) begin
            if (v[l]) begin
                t[l*4 +: 4]  = tags[l*4 +: 4];
                d[l*32 +: 32] = vals[l*32 +: 32];
            end
        end
        return {v, t, d, take, pc};
    endfunction

    task automatic set_tag(input int i, input logic [3:0] tag);
        fu_rob[i]  = tag;
        fu_rd_v[i] = 32'hA000_0000 | {28'd0, tag};
    endtask

    // Drive one cycle; expected lanes appear on the CDB the next cycle.
    task automatic step(input logic r, input logic fl, input logic [4:0] v, input logic [4:0] br,
                        input logic [4:0] exp_rdy, input logic [2:0] ev, input logic [11:0] etags,
                        input logic etake, input logic [31:0] epc);
        logic [95:0] evals;
        rst          = r;
        move_flush   = fl;
        fu_valid     = v;
        fu_is_branch = br;
        for (int l = 0; l < 3; l++)
            evals[l*32 +: 32] = 32'hA000_0000 | {28'd0, etags[l*4 +: 4]};
        exp_q.push_back(pack_bundle(ev, etags, evals, etake, epc));
        due_q.push_back(cyc + 1);
        @(negedge clk);
        checks++;
        if (fu_ready !== exp_rdy) begin
            fails++;
            $display("FAIL fu_ready cyc=%0d got=%b exp=%b", cyc, fu_ready, exp_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            exp = exp_q.pop_front();
            got = pack_bundle(cdb_valid, cdb_rob, cdb_rd_v, cdb_branch_take, cdb_branch_pc);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL cdb_bundle cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) set_tag(i, 4'(i + 1));
        fu_branch_take = 5'b11111;
        fu_branch_pc   = {32'h280, 32'h200, 32'h180, 32'h100, 32'h080};
        @(posedge clk);
        #1;
        // Reset with requests present: nothing granted, lanes idle
        step(1, 0, 5'b11111, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        step(1, 0, 5'b11111, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        step(0, 0, 5'b00000, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        // All valid, no branches: FU0,1,2 then FU3,4,0
        step(0, 0, 5'b11111, 5'b00000, 5'b00111, 3'b111, {4'd3, 4'd2, 4'd1}, 0, 32'h0);
        step(0, 0, 5'b11111, 5'b00000, 5'b11001, 3'b111, {4'd1, 4'd5, 4'd4}, 0, 32'h0);
        // Flush with three requests, then the held requests restart at FU0
        step(0, 1, 5'b00111, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        step(0, 0, 5'b00111, 5'b00000, 5'b00111, 3'b111, {4'd3, 4'd2, 4'd1}, 0, 32'h0);
        step(0, 1, 5'b00000, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        // Two branches: one per cycle
        step(0, 0, 5'b11111, 5'b01010, 5'b00111, 3'b111, {4'd3, 4'd2, 4'd1}, 1, 32'h100);
        step(0, 0, 5'b11111, 5'b01010, 5'b11001, 3'b111, {4'd1, 4'd5, 4'd4}, 1, 32'h200);
        step(0, 1, 5'b00000, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        // Branch FU0 granted, branch FU1 skipped, non-branch FU3 granted
        step(0, 0, 5'b01011, 5'b00011, 5'b01001, 3'b011, {4'd0, 4'd4, 4'd1}, 1, 32'h080);
        checks++;
        if (dut.rr_ptr !== 3'd4) begin
            fails++;
            $display("FAIL rr_ptr got=%0d exp=4", dut.rr_ptr);
        end
        // FU4 alone at rr_ptr=4, then idle
        set_tag(4, 4'd7);
        step(0, 0, 5'b10000, 5'b00000, 5'b10000, 3'b001, {4'd0, 4'd0, 4'd7}, 0, 32'h0);
        step(0, 0, 5'b00000, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        // Pointer wrapped to 0 after granting FU4
        step(0, 0, 5'b01111, 5'b00000, 5'b00111, 3'b111, {4'd3, 4'd2, 4'd1}, 0, 32'h0);
        // Flush together with reset
        step(1, 1, 5'b11111, 5'b00100, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        step(0, 0, 5'b00000, 5'b00000, 5'b00000, 3'b000, 12'h000, 0, 32'h0);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the CDB_SIZE common-data-bus lanes among NUM_FU functional-unit result ports (ALU, MUL, DIV, LSU, BR).
- Selects up to CDB_SIZE finished results per cycle by round-robin priority and registers them onto the CDB that feeds the reorder buffer and the reservation stations.
- Guarantees the bus carries at most one branch/jump result per cycle, because the ROB accepts a single cdb_branch_take/cdb_branch_pc pair.
- Drops everything on move_flush.

Parameters:
- NUM_FU, 5, number of requesting functional-unit result ports.
- CDB_SIZE, 3, number of CDB lanes driven per cycle (CDB_SIZE <= NUM_FU).
- ROB_DEPTH, 4, bit width of ROB index tags.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- move_flush  in  1  pipeline flush; clears in-flight CDB state
- fu_valid  in  1 x NUM_FU  result ready at FU i
- fu_ready  out  1 x NUM_FU  grant; FU i result accepted this cycle
- fu_rob  in  ROB_DEPTH x NUM_FU  ROB tag of FU i result
- fu_rd_v  in  32 x NUM_FU  result value
- fu_is_branch  in  1 x NUM_FU  result is a br/jal/jalr outcome
- fu_branch_take  in  1 x NUM_FU  redirect requested
- fu_branch_pc  in  32 x NUM_FU  redirect target
- cdb_valid  out  1 x CDB_SIZE  lane valid
- cdb_rob  out  ROB_DEPTH x CDB_SIZE  lane ROB tag
- cdb_rd_v  out  32 x CDB_SIZE  lane value
- cdb_branch_take  out  1  take flag of this cycle's branch lane, 0 if none
- cdb_branch_pc  out  32  target of this cycle's branch lane, 0 if none

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous, active-high.
- Reset values: all cdb_* outputs are 0 and rr_ptr is 0. fu_ready is combinational and is all 0 during the rst cycle.

Handshake:
- A transfer occurs when fu_valid[i] and fu_ready[i] are both high in the same cycle.
- fu_ready[i] never depends on fu_ready of other FUs from a later cycle.
- The FU holds its payload stable while fu_valid is high and fu_ready is low.

Selection (combinational, per cycle):
- Scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU.
- Grant each valid FU until CDB_SIZE grants are made.
- Branch rule: once one fu_is_branch requester is granted, later branch requesters in the scan are skipped. Non-branch requesters after them may still be granted.
- Granted FUs fill lanes 0,1,2... in scan order. Lanes left over carry valid 0.

Latency:
- Registered output, one cycle. A result accepted in cycle N appears on cdb_* in cycle N+1, for exactly one cycle.

Branch fields:
- cdb_branch_take/pc take the values of the granted branch FU.
- If no branch FU was granted that cycle, both are 0.

Round-robin pointer:
- If any grant occurred, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
- Otherwise rr_ptr holds.

Fairness:
- A continuously valid FU is granted within NUM_FU cycles.

Flush:
- When move_flush is high, fu_ready is all 0 that cycle.
- Next cycle, all cdb_valid are 0 and both branch fields are 0.
- rr_ptr resets to 0.
- move_flush has the same effect as rst on state, and flush in the same cycle as rst is identical to rst.

Other boundary cases:
- No requesters: the lanes go idle (valid 0) next cycle.
- ROB tag collisions between lanes are not checked. The issue logic guarantees unique tags.

Decomposition:
- Shared package rv32i_types gains the cdb_entry_t struct {rob[ROB_DEPTH-1:0], rd_v[31:0], is_branch, branch_take, branch_pc[31:0]}. The arbiter uses it internally for its lane registers.
- One natural sub-module: rr_lane_picker. It is purely combinational, takes valid, is_branch and rr_ptr, and produces the grant vector, the per-lane FU index, and the last-granted index.

Test Plan (NUM_FU=5, CDB_SIZE=3):
- Reset then idle: rst=1 for 2 cycles -> all cdb_valid=0, fu_ready=0, cdb_branch_pc=0.
- All five FUs valid, none branch, rr_ptr=0, tags 1..5: cycle N grants FU0,1,2 -> N+1 lanes carry tags 1,2,3. Cycle N+1 grants FU3,4,0 -> lanes carry tags 4,5,1 at N+2.
- FU1 and FU3 both branch (take=1, pc 0x100 and 0x200), FU0/2/4 valid non-branch, rr_ptr=0: grants FU0,1,2 -> cdb_branch_pc=0x100. Next cycle grants FU3,4,0 -> cdb_branch_pc=0x200.
- rr_ptr=0, branch FU0 and FU1 valid, FU2 idle, non-branch FU3 valid: grants FU0 and FU3 (FU1 skipped) -> lanes 0,1 valid, lane 2 invalid, rr_ptr becomes 4.
- move_flush in the same cycle as three valid requests: fu_ready=00000 -> next cycle cdb_valid all 0 and rr_ptr=0. Requests held the cycle after are granted starting from FU0.
- Stall hold: FU4 valid alone with tag 7 while rr_ptr=4 -> granted immediately. Lane 0 shows tag 7 next cycle, and the following cycle shows valid 0 if no new request.
